// File: rtl/rsa_result_checker.sv
// Post-run self-check for the RSA32 demo: walks result RAM and golden ROM in lockstep,
// counts mismatching words and latches a sticky good/bad verdict plus diagnostics.
module rsa_result_checker #(
    parameter int DW    = 32,
    parameter int AW    = 4,
    parameter int N_VEC = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          md_start,
    input  logic          md_done,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] res_rdata,
    input  logic [DW-1:0] gold_rdata,
    output logic          chk_busy,
    output logic          chk_done,
    output logic          good,
    output logic          bad,
    output logic [AW:0]   err_cnt,
    output logic [AW-1:0] first_err_addr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(N_VEC - 1);
    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};

    state_t        state_r;
    state_t        state_nxt_s;
    logic          cmp_vld_r;
    logic [AW-1:0] cmp_addr_r;
    logic          mismatch_s;

    // Next-state selection; md_start aborts from any state.
    always_comb begin
        state_nxt_s = state_r;
        if (md_start) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (md_done) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (mem_addr == LAST_ADDR) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_DRAIN: state_nxt_s = ST_DONE;
                ST_DONE:  state_nxt_s = ST_IDLE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Word comparison, qualified by the delayed read-valid flag.
    always_comb begin
        mismatch_s = 1'b0;
        if (cmp_vld_r) begin
            mismatch_s = (res_rdata != gold_rdata);
        end else begin
            mismatch_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Read sequencing and status flags, derived from the upcoming state so they stay registered.
    always_ff @(posedge clk) begin
        if (!rstn || md_start) begin
            mem_rd   <= 1'b0;
            mem_addr <= {AW{1'b0}};
            chk_busy <= 1'b0;
            chk_done <= 1'b0;
        end else begin
            chk_busy <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
            chk_done <= (state_nxt_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (md_done) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= {AW{1'b0}};
                    end else begin
                        mem_rd   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // The address parks on the last word instead of wrapping.
                    if (mem_addr == LAST_ADDR) begin
                        mem_rd <= 1'b0;
                    end else begin
                        mem_addr <= mem_addr + ADDR_ONE;
                    end
                end
                default: mem_rd <= 1'b0;
            endcase
        end
    end

    // Align the read request with the memory's one-cycle data latency.
    always_ff @(posedge clk) begin
        if (!rstn || md_start) begin
            cmp_vld_r  <= 1'b0;
            cmp_addr_r <= {AW{1'b0}};
        end else begin
            cmp_vld_r  <= mem_rd;
            cmp_addr_r <= mem_addr;
        end
    end

    // Error accounting and sticky verdict.
    always_ff @(posedge clk) begin
        if (!rstn || md_start) begin
            err_cnt        <= {(AW+1){1'b0}};
            first_err_addr <= {AW{1'b0}};
            good           <= 1'b0;
            bad            <= 1'b0;
        end else if ((state_r == ST_IDLE) && md_done) begin
            err_cnt        <= {(AW+1){1'b0}};
            first_err_addr <= {AW{1'b0}};
            good           <= 1'b0;
            bad            <= 1'b0;
        end else begin
            if (mismatch_s) begin
                err_cnt <= err_cnt + CNT_ONE;
                if (err_cnt == {(AW+1){1'b0}}) begin
                    first_err_addr <= cmp_addr_r;
                end else begin
                    first_err_addr <= first_err_addr;
                end
            end else begin
                err_cnt <= err_cnt;
            end
            // DONE follows the final compare, so err_cnt is already complete here.
            if (state_r == ST_DONE) begin
                good <= (err_cnt == {(AW+1){1'b0}});
                bad  <= (err_cnt != {(AW+1){1'b0}});
            end else begin
                good <= good;
                bad  <= bad;
            end
        end
    end

endmodule

// File: tb/tb_rsa_result_checker.sv
// Bench for rsa_result_checker: synchronous memory models feed the checker, and a
// word-by-word reference count of mismatches gives the expected verdict and timing.
module tb_rsa_result_checker;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int N_VEC = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          md_start;
    logic          md_done;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] res_rdata;
    logic [DW-1:0] gold_rdata;
    logic          chk_busy;
    logic          chk_done;
    logic          good;
    logic          bad;
    logic [AW:0]   err_cnt;
    logic [AW-1:0] first_err_addr;

    logic [DW-1:0] res_mem  [N_VEC];
    logic [DW-1:0] gold_mem [N_VEC];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rsa_result_checker #(.DW(DW), .AW(AW), .N_VEC(N_VEC)) dut (
        .clk(clk), .rstn(rstn), .md_start(md_start), .md_done(md_done),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .res_rdata(res_rdata), .gold_rdata(gold_rdata),
        .chk_busy(chk_busy), .chk_done(chk_done), .good(good), .bad(bad),
        .err_cnt(err_cnt), .first_err_addr(first_err_addr)
    );

    // Synchronous-read memories with one cycle of latency.
    always @(posedge clk) begin
        if (mem_rd) begin
            res_rdata  <= res_mem[mem_addr];
            gold_rdata <= gold_mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_equal();
        for (int i = 0; i < N_VEC; i++) begin
            gold_mem[i] = $urandom;
            res_mem[i]  = gold_mem[i];
        end
    endtask

    // Reference: number of differing words and the lowest differing index.
    task automatic model(output int n_err, output int first);
        n_err = 0;
        first = 0;
        for (int i = N_VEC - 1; i >= 0; i--) begin
            if (res_mem[i] !== gold_mem[i]) begin
                n_err++;
                first = i;
            end
        end
    endtask

    // md_done at edge E0, then watch cycles 1..30; optional re-pulse or abort at a given cycle.
    task automatic run(input string name, input int restart_cyc, input int abort_cyc);
        int  exp_e, exp_f;
        int  n_rd, n_busy, n_done, done_cyc;
        bit  addr_ok;
        model(exp_e, exp_f);
        n_rd = 0; n_busy = 0; n_done = 0; done_cyc = 0; addr_ok = 1'b1;
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (mem_rd) begin
                if (mem_addr !== AW'(n_rd)) addr_ok = 1'b0;
                n_rd++;
            end
            if (chk_busy) n_busy++;
            if (chk_done) begin
                n_done++;
                done_cyc = cyc;
            end
            md_done  = (cyc == restart_cyc);
            md_start = (cyc == abort_cyc);
            tick();
        end
        md_done  = 1'b0;
        md_start = 1'b0;
        check({name, ".addr_seq"}, 64'(addr_ok), 64'd1);
        if (abort_cyc > 0) begin
            check({name, ".rd_cycles"}, 64'(n_rd), 64'(abort_cyc));
            check({name, ".busy_cycles"}, 64'(n_busy), 64'(abort_cyc));
            check({name, ".no_done"}, 64'(n_done), 64'd0);
            check({name, ".cleared"}, {58'd0, good, bad, err_cnt}, 64'd0);
            check({name, ".first_clr"}, 64'(first_err_addr), 64'd0);
        end else begin
            check({name, ".rd_cycles"}, 64'(n_rd), 64'(N_VEC));
            check({name, ".busy_cycles"}, 64'(n_busy), 64'(N_VEC + 1));
            check({name, ".done_cnt"}, 64'(n_done), 64'd1);
            check({name, ".done_cyc"}, 64'(done_cyc), 64'(N_VEC + 2));
            check({name, ".good"}, 64'(good), 64'(exp_e == 0));
            check({name, ".bad"}, 64'(bad), 64'(exp_e != 0));
            check({name, ".err_cnt"}, 64'(err_cnt), 64'(exp_e));
            if (exp_e != 0) check({name, ".first_err"}, 64'(first_err_addr), 64'(exp_f));
        end
    endtask

    initial begin
        int n_dn;
        rstn = 1'b0; md_start = 1'b0; md_done = 1'b0;
        fill_equal();
        tick(); tick(); tick();
        check("reset_state", {46'd0, mem_rd, mem_addr, chk_busy, chk_done, good, bad,
              err_cnt, first_err_addr}, 64'd0);
        rstn = 1'b1;
        tick();

        // Establish a bad verdict, then reset in the middle of the next run.
        res_mem[3] = gold_mem[3] ^ 32'h0000_0100;
        run("pre_reset", 0, 0);
        md_done = 1'b1; tick(); md_done = 1'b0;
        tick(); tick();
        rstn = 1'b0; tick(); tick(); rstn = 1'b1;
        check("reset_midrun", {46'd0, mem_rd, mem_addr, chk_busy, chk_done, good, bad,
              err_cnt, first_err_addr}, 64'd0);
        n_dn = 0;
        for (int c = 0; c < 25; c++) begin
            if (chk_done || chk_busy) n_dn++;
            tick();
        end
        check("reset_no_done", 64'(n_dn), 64'd0);

        fill_equal();
        run("all_equal", 0, 0);

        fill_equal();
        res_mem[5] = 32'h0000_0001; gold_mem[5] = 32'h0000_0000;
        run("word5", 0, 0);

        fill_equal();
        res_mem[0] = ~gold_mem[0]; res_mem[15] = gold_mem[15] + 32'd1;
        run("ends", 0, 0);

        fill_equal();
        for (int i = 0; i < N_VEC; i++) res_mem[i] = ~gold_mem[i];
        run("all_bad", 0, 0);

        for (int r = 0; r < 4; r++) begin
            fill_equal();
            for (int i = 0; i < N_VEC; i++)
                if ($urandom_range(3, 0) == 0) res_mem[i] = gold_mem[i] ^ (32'd1 << $urandom_range(31, 0));
            run($sformatf("rand%0d", r), 0, 0);
        end

        fill_equal();
        res_mem[9] = ~gold_mem[9];
        run("redone", 4, 0);

        fill_equal();
        res_mem[0] = ~gold_mem[0]; res_mem[1] = ~gold_mem[1];
        run("abort", 0, 6);

        // Good verdict, then simultaneous start/done from IDLE.
        fill_equal();
        run("pre_both", 0, 0);
        md_start = 1'b1; md_done = 1'b1;
        tick();
        md_start = 1'b0; md_done = 1'b0;
        n_dn = 0;
        for (int c = 0; c < 25; c++) begin
            if (chk_done || chk_busy || mem_rd) n_dn++;
            tick();
        end
        check("both_stay_idle", 64'(n_dn), 64'd0);
        check("both_cleared", {58'd0, good, bad, err_cnt}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
